// File: rtl/conv_psum_acc.sv
// Partial-sum accumulator behind the Tin-channel adder tree: sums one group of beats into a
// pixel partial sum and hands it out through a 2-entry queue. Build with PSUM_SAT_EN to clamp instead of wrap.
module conv_psum_acc #(
  parameter int IN_WIDTH  = 22,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  i_dat,
  input  logic                 i_vld,
  input  logic                 i_first,
  input  logic                 i_last,
  output logic                 i_rdy,
  input  logic                 i_clr,
  output logic [ACC_WIDTH-1:0] o_dat,
  output logic                 o_vld,
  input  logic                 o_rdy,
  output logic                 o_err,
  output logic                 o_sat
);

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e                      state_q;
  logic signed [IN_WIDTH-1:0]  dat_s;
  logic signed [ACC_WIDTH-1:0] acc_q, ext, base, res;
  logic [ACC_WIDTH-1:0]        head_q, head_d, tail_q, tail_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic                        acc_en, push, pop, restart, seq_bad;

  assign dat_s   = i_dat;
  assign ext     = ACC_WIDTH'(dat_s);
  assign acc_en  = i_vld && i_rdy;
  // A beat that starts a group (legally or not) discards whatever partial sum exists.
  assign restart = (state_q == IDLE) || i_first;
  assign base    = restart ? '0 : acc_q;
  assign seq_bad = (state_q == IDLE) ? !i_first : i_first;
  assign push    = acc_en && i_last;
  assign pop     = o_vld && o_rdy;

`ifdef PSUM_SAT_EN
  logic signed [ACC_WIDTH:0] sum;
  logic                      ovf, sat_q, sat_d;

  assign sum   = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(ext);
  assign ovf   = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
  assign res   = !ovf ? sum[ACC_WIDTH-1:0] :
                 sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  assign sat_d = (acc_en && ovf) || (sat_q && !i_clr);
  assign o_sat = sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end
`else
  assign res   = base + ext;
  assign o_sat = 1'b0;
`endif

  assign err_d = (acc_en && seq_bad) || (err_q && !i_clr);

  // Queue: head lives directly in the output register, tail is the overflow slot.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = res;
        else               tail_d = res;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) head_d = res;
        else begin
          head_d = tail_q;
          tail_d = res;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      if (acc_en) begin
        if (i_last) begin
          acc_q   <= '0;
          state_q <= IDLE;
        end else begin
          acc_q   <= res;
          state_q <= ACCUM;
        end
      end
    end
  end

  assign i_rdy = cnt_q != 2'd2;
  assign o_vld = cnt_q != 2'd0;
  assign o_dat = head_q;
  assign o_err = err_q;

endmodule

// File: tb/tb_conv_psum_acc.sv
// Directed bench for conv_psum_acc: a scoreboard queue checks every popped result,
// plus point checks on latency, backpressure, flags, saturation and reset.
module tb_conv_psum_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] i_dat;
  logic        i_vld, i_first, i_last, i_clr, o_rdy;
  logic        i_rdy, o_vld, o_err, o_sat;
  logic [31:0] o_dat;
  logic        i_rdy24, o_vld24, o_err24, o_sat24;
  logic [23:0] o_dat24;

  int          total  = 0;
  int          passes = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  conv_psum_acc dut (
    .clk(clk), .rst_n(rst_n), .i_dat(i_dat), .i_vld(i_vld), .i_first(i_first),
    .i_last(i_last), .i_rdy(i_rdy), .i_clr(i_clr), .o_dat(o_dat), .o_vld(o_vld),
    .o_rdy(o_rdy), .o_err(o_err), .o_sat(o_sat)
  );

  conv_psum_acc #(.IN_WIDTH(22), .ACC_WIDTH(24)) u24 (
    .clk(clk), .rst_n(rst_n), .i_dat(i_dat), .i_vld(i_vld), .i_first(i_first),
    .i_last(i_last), .i_rdy(i_rdy24), .i_clr(i_clr), .o_dat(o_dat24), .o_vld(o_vld24),
    .o_rdy(o_rdy), .o_err(o_err24), .o_sat(o_sat24)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Drive one beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic beat(input int d, input bit f, input bit l);
    int n;
    i_dat = 22'(d); i_first = f; i_last = l; i_vld = 1'b1;
    n = 0;
    while (!i_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("rdy_timeout", i_rdy, 1);
    @(posedge clk); #1;
    i_vld = 1'b0; i_first = 1'b0; i_last = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && o_vld && o_rdy) begin
      chk("sb_extra", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("sb_dat", o_dat, exp_q.pop_front());
    end
  end

  initial begin
    logic [23:0] exp24;
    logic        expsat;
    rst_n = 1'b0; i_dat = '0; i_vld = 1'b0; i_first = 1'b0; i_last = 1'b0;
    i_clr = 1'b0; o_rdy = 1'b1;
    #12;
    chk("rst_vld", o_vld, 0);
    chk("rst_dat", o_dat, 0);
    chk("rst_err", o_err, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_rdy", i_rdy, 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Four-beat group
    beat(100, 1, 0); beat(-30, 0, 0); beat(7, 0, 0);
    chk("t1_vld_early", o_vld, 0);
    exp_q.push_back(32'd78);
    beat(1, 0, 1);
    chk("t1_vld", o_vld, 1);
    chk("t1_dat", o_dat, 32'd78);
    @(posedge clk); #1;
    chk("t1_vld_drop", o_vld, 0);

    // One-beat negative group
    exp_q.push_back(32'hFFFF_FFFB);
    beat(-5, 1, 1);
    chk("t2_dat", o_dat, 32'hFFFF_FFFB);
    chk("t2_err", o_err, 0);
    @(posedge clk); #1;

    // Backpressure: queue fills at two, third beat held
    o_rdy = 1'b0;
    exp_q.push_back(32'd1); beat(1, 1, 1);
    exp_q.push_back(32'd2); beat(2, 1, 1);
    chk("t3_rdy_full", i_rdy, 0);
    chk("t3_vld_full", o_vld, 1);
    exp_q.push_back(32'd3);
    i_dat = 22'd3; i_first = 1'b1; i_last = 1'b1; i_vld = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t3_rdy_held", i_rdy, 0);
    chk("t3_dat_held", o_dat, 32'd1);
    o_rdy = 1'b1;
    beat(3, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_vld_empty", o_vld, 0);
    chk("t3_dat_keep", o_dat, 32'd3);

    // Overflow of a 24-bit accumulator
`ifdef PSUM_SAT_EN
    exp24 = 24'd8388607; expsat = 1'b1;
`else
    exp24 = 24'(-6291461); expsat = 1'b0;
`endif
    chk("t4_sat_pre", o_sat24, 0);
    exp_q.push_back(32'd10485755);
    beat(2097151, 1, 0);
    repeat (3) beat(2097151, 0, 0);
    beat(2097151, 0, 1);
    chk("t4_dat24", o_dat24, exp24);
    chk("t4_sat24", o_sat24, expsat);
    chk("t4_dat32", o_dat, 32'd10485755);
    chk("t4_sat32", o_sat, 0);
    @(posedge clk); #1;

    // Sequencing errors and sticky clear
    beat(4, 0, 0);
    exp_q.push_back(32'd10);
    beat(6, 0, 1);
    chk("t5_dat", o_dat, 32'd10);
    chk("t5_err", o_err, 1);
    i_clr = 1'b1; @(posedge clk); #1 i_clr = 1'b0;
    chk("t5_clr", o_err, 0);
    beat(5, 1, 0);
    exp_q.push_back(32'd9);
    beat(9, 1, 1);
    chk("t5_restart_dat", o_dat, 32'd9);
    chk("t5_restart_err", o_err, 1);
    i_clr = 1'b1; @(posedge clk); #1 i_clr = 1'b0;
    chk("t5_clr2", o_err, 0);
    i_clr = 1'b1;
    exp_q.push_back(32'd1);
    beat(1, 0, 1);
    i_clr = 1'b0;
    chk("t5_set_wins", o_err, 1);
    @(posedge clk); #1;

    // Asynchronous reset mid-group
    beat(50, 1, 0); beat(60, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", o_vld, 0);
    chk("t6_rst_dat", o_dat, 0);
    chk("t6_rst_err", o_err, 0);
    chk("t6_rst_sat24", o_sat24, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.push_back(32'd7);
    beat(3, 1, 0); beat(4, 0, 1);
    chk("t6_dat", o_dat, 32'd7);
    repeat (2) @(posedge clk);
    #1;
    chk("end_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/conv_psum_acc.md
Name: conv_psum_acc

Overview:
- Partial-sum accumulator directly downstream of the Tin-channel adder tree in the CONV MAC path.
- Each tree result covers one kernel position over one Tin-channel tile. This block sums a group of consecutive results (Kx*Ky*ceil(CH/Tin) beats) into one output-pixel partial sum.
- Delivers each result through a 2-entry valid/ready output queue to the requant/activation stage.

Parameters:
- IN_WIDTH, 22, width of the signed tree result (product width + log2 Tin).
- ACC_WIDTH, 32, width of the signed accumulator and output; must be >= IN_WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_dat  input  IN_WIDTH  signed tree result.
- i_vld  input  1  i_dat valid.
- i_first  input  1  beat is the first of a group; qualified by i_vld.
- i_last  input  1  beat is the last of a group; qualified by i_vld.
- i_rdy  output  1  block accepts a beat this cycle.
- i_clr  input  1  synchronous clear of the sticky flags.
- o_dat  output  ACC_WIDTH  signed accumulated group sum.
- o_vld  output  1  o_dat valid.
- o_rdy  input  1  downstream accepts o_dat.
- o_err  output  1  sticky group-sequencing error.
- o_sat  output  1  sticky saturation event (PSUM_SAT_EN only).

Behaviour:
- Reset (async, rst_n=0): acc=0, state=IDLE, queue count=0, o_vld=0, o_dat=0, o_err=0, o_sat=0. Rebuilding any partial group is upstream's responsibility.
- Beat accepted when i_vld && i_rdy. i_rdy = (queue count != 2), registered-state based, with no combinational path from o_rdy. Every beat stalls while the queue is full.
- Input is sign-extended to ACC_WIDTH before any add.
- State IDLE:
  - Accepted beat: acc <= sext(i_dat); go to ACCUM.
  - If i_first=0 on that beat: set o_err; the beat still starts the group.
- State ACCUM:
  - Accepted beat with i_first=0: acc <= acc + sext(i_dat).
  - Accepted beat with i_first=1: set o_err, discard the partial sum, acc <= sext(i_dat).
- Any accepted beat with i_last=1: push the group result (the value acc would take) into the queue, acc <= 0, go to IDLE.
  - i_first=1 with i_last=1 is a legal one-beat group.
- Latency: last beat accepted on edge t; result at o_dat with o_vld=1 after edge t, provided the queue was empty.
- Queue:
  - 2-entry FIFO, head registered onto o_dat.
  - Pop on o_vld && o_rdy.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - o_dat holds its value while o_vld && !o_rdy. o_dat keeps its last value when the queue is empty.
- Arithmetic without PSUM_SAT_EN: two's-complement wrap modulo 2^ACC_WIDTH.
- Sticky flags clear only on i_clr=1 or reset.
  - If i_clr and a set event occur in the same cycle, the set wins.
- No beat counter limit: group length is unbounded.

Optional Feature:
- Macro: PSUM_SAT_EN.
- Defined:
  - Each add is computed at ACC_WIDTH+1 bits and clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Any clamp sets o_sat.
  - Saturated acc continues accumulating from the clamped value.
- Undefined: adds wrap; o_sat is tied to 0.

Test Plan:
- Beats 100, -30, 7, 1 (first on beat 1, last on beat 4), o_rdy=1 -> o_dat=78, o_vld high exactly one cycle after the last beat.
- Single beat -5 with first=last=1 -> o_dat=0xFFFFFFFB, o_err=0.
- o_rdy=0; one-beat groups 1, 2, 3 -> i_rdy drops after 2 pushes and the third beat is held; raise o_rdy -> outputs 1, 2, 3 in order, one per cycle, no loss or duplication.
- ACC_WIDTH=24; 5 beats of 2097151 in one group:
  - With PSUM_SAT_EN -> o_dat=8388607, o_sat=1.
  - Without it -> o_dat=-6291461, o_sat=0.
- Beat 4 with first=0 in IDLE, then 6 with last=1 -> o_dat=10, o_err=1; pulse i_clr -> o_err=0. Mid-group beat with first=1 (value 9, last=1) -> o_dat=9, o_err=1.
- Beats 50, 60, then rst_n pulled low asynchronously mid-group -> o_vld=0, o_dat=0 immediately; after release, group 3, 4 (first/last) -> o_dat=7.
